// File: rtl/key_param_pkg.sv
// rtl/key_param_pkg.sv - shared constants and repeat-state type for key_param_controller
package key_param_pkg;

  localparam int KEY_CODE_W = 9;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_DELAY,
    RS_REPEAT
  } repeat_state_e;

  // Letters name the role each default code plays: D/A step channel 0, W/S step channel 1
  localparam logic [KEY_CODE_W-1:0] SC_D = 9'h01D;
  localparam logic [KEY_CODE_W-1:0] SC_A = 9'h01B;
  localparam logic [KEY_CODE_W-1:0] SC_W = 9'h023;
  localparam logic [KEY_CODE_W-1:0] SC_S = 9'h01C;

endpackage

// File: rtl/key_param_channel.sv
// rtl/key_param_channel.sv - one bounded up/down parameter register with saturate or wrap
module key_param_channel #(
  parameter int              VAL_W   = 3,
  parameter logic [VAL_W-1:0] MIN_VAL = '0,
  parameter logic [VAL_W-1:0] MAX_VAL = '1,
  parameter logic [VAL_W-1:0] RST_VAL = '0,
  parameter bit              WRAP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_up_i,
  input  logic             step_dn_i,
  output logic [VAL_W-1:0] val_o,
  output logic             changed_o
);

  logic [VAL_W-1:0] val_q, val_d;
  logic             changed_q;

  always_comb begin
    val_d = val_q;
    if (step_up_i) begin
      if (val_q < MAX_VAL)  val_d = val_q + VAL_W'(1);
      else if (WRAP)        val_d = MIN_VAL;
    end else if (step_dn_i) begin
      if (val_q > MIN_VAL)  val_d = val_q - VAL_W'(1);
      else if (WRAP)        val_d = MAX_VAL;
    end
  end

  // changed rises together with the new value, so it marks its first cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q     <= RST_VAL;
      changed_q <= 1'b0;
    end else begin
      val_q     <= val_d;
      changed_q <= (val_d != val_q);
    end
  end

  assign val_o     = val_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/key_param_controller.sv
// rtl/key_param_controller.sv - keyboard-driven parameter channels; optional auto-repeat
// under KEY_PARAM_AUTO_REPEAT_EN (IDLE/DELAY/REPEAT hold FSM).
module key_param_controller
  import key_param_pkg::*;
#(
  parameter int                           NUM_CH        = 2,
  parameter int                           VAL_W         = 3,
  parameter logic [NUM_CH*KEY_CODE_W-1:0] UP_CODES      = {SC_W, SC_D},
  parameter logic [NUM_CH*KEY_CODE_W-1:0] DN_CODES      = {SC_S, SC_A},
  parameter logic [NUM_CH*VAL_W-1:0]      MIN_VALS      = {3'd1, 3'd1},
  parameter logic [NUM_CH*VAL_W-1:0]      MAX_VALS      = {3'd3, 3'd5},
  parameter logic [NUM_CH*VAL_W-1:0]      RST_VALS      = {3'd2, 3'd3},
  parameter int                           WRAP          = 0,
  parameter int                           REPEAT_DELAY  = 50_000_000,
  parameter int                           REPEAT_PERIOD = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [KEY_CODE_W-1:0]   last_change,
  input  logic [511:0]            key_down,
  output logic [NUM_CH*VAL_W-1:0] vals,
  output logic [NUM_CH-1:0]       changed
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            hit;
  logic [CH_W-1:0] hit_ch;
  logic            hit_up;
  logic            press_step;

  // Later assignments win: scanning high-to-low, UP after DN, gives lowest UP slot priority
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    hit_up = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (last_change == DN_CODES[i*KEY_CODE_W +: KEY_CODE_W]) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
        hit_up = 1'b0;
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (last_change == UP_CODES[i*KEY_CODE_W +: KEY_CODE_W]) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
        hit_up = 1'b1;
      end
    end
  end

  assign press_step = key_valid && key_down[last_change] && hit;

  logic            step_en;
  logic [CH_W-1:0] step_ch;
  logic            step_up;

`ifdef KEY_PARAM_AUTO_REPEAT_EN
  localparam int DLY_W = $clog2(REPEAT_DELAY + 1);
  localparam int PER_W = $clog2(REPEAT_PERIOD + 1);

  repeat_state_e         state_q;
  logic [KEY_CODE_W-1:0] held_code_q;
  logic [CH_W-1:0]       held_ch_q;
  logic                  held_up_q;
  logic [DLY_W-1:0]      dly_cnt_q;
  logic [PER_W-1:0]      per_cnt_q;
  logic                  held_down;
  logic                  dly_done;
  logic                  per_done;
  logic                  rpt_step;

  assign held_down = key_down[held_code_q];
  assign dly_done  = (dly_cnt_q == DLY_W'(REPEAT_DELAY - 1));
  assign per_done  = (per_cnt_q == PER_W'(REPEAT_PERIOD - 1));
  // A fresh press always pre-empts a repeat step in the same cycle
  assign rpt_step  = !press_step && held_down &&
                     ((state_q == RS_DELAY && dly_done) || (state_q == RS_REPEAT && per_done));

  assign step_en = press_step || rpt_step;
  assign step_ch = press_step ? hit_ch : held_ch_q;
  assign step_up = press_step ? hit_up : held_up_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RS_IDLE;
      held_code_q <= '0;
      held_ch_q   <= '0;
      held_up_q   <= 1'b0;
      dly_cnt_q   <= '0;
      per_cnt_q   <= '0;
    end else if (press_step) begin
      state_q     <= RS_DELAY;
      held_code_q <= last_change;
      held_ch_q   <= hit_ch;
      held_up_q   <= hit_up;
      dly_cnt_q   <= '0;
      per_cnt_q   <= '0;
    end else begin
      case (state_q)
        RS_DELAY: begin
          if (!held_down) begin
            state_q   <= RS_IDLE;
            dly_cnt_q <= '0;
          end else if (dly_done) begin
            state_q   <= RS_REPEAT;
            dly_cnt_q <= '0;
            per_cnt_q <= '0;
          end else begin
            dly_cnt_q <= dly_cnt_q + DLY_W'(1);
          end
        end
        RS_REPEAT: begin
          if (!held_down) begin
            state_q   <= RS_IDLE;
            per_cnt_q <= '0;
          end else if (per_done) begin
            per_cnt_q <= '0;
          end else begin
            per_cnt_q <= per_cnt_q + PER_W'(1);
          end
        end
        default: begin
          state_q <= RS_IDLE;
        end
      endcase
    end
  end
`else
  assign step_en = press_step;
  assign step_ch = hit_ch;
  assign step_up = hit_up;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    key_param_channel #(
      .VAL_W   (VAL_W),
      .MIN_VAL (MIN_VALS[g*VAL_W +: VAL_W]),
      .MAX_VAL (MAX_VALS[g*VAL_W +: VAL_W]),
      .RST_VAL (RST_VALS[g*VAL_W +: VAL_W]),
      .WRAP    (WRAP != 0)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .step_up_i (step_en && step_up && (step_ch == CH_W'(g))),
      .step_dn_i (step_en && !step_up && (step_ch == CH_W'(g))),
      .val_o     (vals[g*VAL_W +: VAL_W]),
      .changed_o (changed[g])
    );
  end

endmodule

// File: tb/tb_key_param_controller.sv
// tb/tb_key_param_controller.sv - randomized and directed bench for key_param_controller
module tb_key_param_controller;

  localparam int RD = 20;
  localparam int RP = 5;
  localparam logic [8:0] K_D = 9'h01D;
  localparam logic [8:0] K_A = 9'h01B;
  localparam logic [8:0] K_W = 9'h023;
  localparam logic [8:0] K_S = 9'h01C;
  localparam logic [8:0] K_X = 9'h029;
`ifdef KEY_PARAM_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = '0;
  logic [511:0] key_down = '0;
  logic [5:0]   vals0, vals1, vals2;
  logic [1:0]   chg0, chg1, chg2;

  int n_checks = 0;
  int n_fail   = 0;

  int         mn[2]  = '{1, 1};
  int         mx[2]  = '{5, 3};
  int         rv[2]  = '{3, 2};
  logic [8:0] upc[2] = '{9'h01D, 9'h023};
  logic [8:0] dnc[2] = '{9'h01B, 9'h01C};
  logic [8:0] pool[5] = '{9'h01D, 9'h01B, 9'h023, 9'h01C, 9'h029};

  // Reference state: [dut][channel]; dut 0 saturates, dut 1 wraps
  int         m_val[2][2];
  bit         m_chg[2][2];
  bit         h_valid = 1'b0;
  logic [8:0] h_code = '0;
  int         h_ch = 0;
  bit         h_up = 1'b0;
  int         next_at = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  key_param_controller #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .vals(vals0), .changed(chg0));

  key_param_controller #(.WRAP(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .vals(vals1), .changed(chg1));

  key_param_controller #(.UP_CODES({9'h0AA, 9'h0AA}), .DN_CODES({9'h0AA, 9'h0AA}),
                         .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut2 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .vals(vals2), .changed(chg2));

  function automatic int stepv(int v, int lo, int hi, bit up, bit wrap);
    if (up) return (v < hi) ? v + 1 : (wrap ? lo : v);
    return (v > lo) ? v - 1 : (wrap ? hi : v);
  endfunction

  function automatic logic [5:0] mv(int d);
    return {3'(m_val[d][1]), 3'(m_val[d][0])};
  endfunction

  function automatic logic [1:0] mc(int d);
    return {m_chg[d][1], m_chg[d][0]};
  endfunction

  task automatic model_step(int ch, bit up);
    for (int d = 0; d < 2; d++) begin
      int nv;
      nv = stepv(m_val[d][ch], mn[ch], mx[ch], up, d == 1);
      m_chg[d][ch] = (nv != m_val[d][ch]);
      m_val[d][ch] = nv;
    end
  endtask

  // Advance the reference by one clock using the inputs currently applied, then clock the DUTs
  task automatic tick();
    bit hit;
    int ch;
    bit up;
    for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) m_chg[d][c] = 1'b0;
    hit = 1'b0; ch = 0; up = 1'b0;
    for (int i = 0; i < 2; i++) if (!hit && last_change == upc[i]) begin hit = 1'b1; ch = i; up = 1'b1; end
    for (int i = 0; i < 2; i++) if (!hit && last_change == dnc[i]) begin hit = 1'b1; ch = i; up = 1'b0; end
    if (rst) begin
      for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) m_val[d][c] = rv[c];
      h_valid = 1'b0;
    end else if (key_valid && key_down[last_change] && hit) begin
      model_step(ch, up);
      if (AUTO) begin
        h_valid = 1'b1; h_code = last_change; h_ch = ch; h_up = up; next_at = cyc + RD;
      end
    end else if (h_valid && !key_down[h_code]) begin
      h_valid = 1'b0;
    end else if (h_valid && cyc == next_at) begin
      model_step(h_ch, h_up);
      next_at = cyc + RP;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic press(logic [8:0] c);
    key_down[c] = 1'b1; key_valid = 1'b1; last_change = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic release_key(logic [8:0] c);
    key_down[c] = 1'b0; key_valid = 1'b1; last_change = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_valid = 1'b0; key_down = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (vals0 !== 6'b010_011) begin n_fail++; $display("FAIL reset_vals0 got=%h exp=%h", vals0, 6'b010_011); end
    n_checks++; if (chg0 !== 2'b00) begin n_fail++; $display("FAIL reset_chg0 got=%b exp=00", chg0); end
    n_checks++; if (vals1 !== 6'b010_011) begin n_fail++; $display("FAIL reset_vals1 got=%h exp=%h", vals1, 6'b010_011); end
    n_checks++; if (vals2 !== 6'b010_011) begin n_fail++; $display("FAIL reset_vals2 got=%h exp=%h", vals2, 6'b010_011); end
    rst = 1'b1;
    press(K_D);
    n_checks++; if (vals0 !== 6'b010_011 || chg0 !== 2'b00) begin n_fail++; $display("FAIL reset_masks_press got=%h/%b exp=13/00", vals0, chg0); end
    do_reset();
  endtask

  task automatic test_single_steps();
    int exp0[3] = '{4, 5, 5};
    int exp1[3] = '{4, 5, 1};
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      press(K_D);
      n_checks++; if (vals0[2:0] !== 3'(exp0[k])) begin n_fail++; $display("FAIL step_ch0_sat[%0d] got=%0d exp=%0d", k, vals0[2:0], exp0[k]); end
      n_checks++; if (vals1[2:0] !== 3'(exp1[k])) begin n_fail++; $display("FAIL step_ch0_wrap[%0d] got=%0d exp=%0d", k, vals1[2:0], exp1[k]); end
      n_checks++; if (chg0 !== mc(0)) begin n_fail++; $display("FAIL step_chg0[%0d] got=%b exp=%b", k, chg0, mc(0)); end
      pulses += chg0[0];
      tick();
      n_checks++; if (chg0 !== 2'b00) begin n_fail++; $display("FAIL chg_one_cycle[%0d] got=%b exp=00", k, chg0); end
      release_key(K_D);
      pulses += chg0[0];
    end
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL step_pulse_count got=%0d exp=2", pulses); end
  endtask

  task automatic test_wrap();
    do_reset();
    press(K_W); release_key(K_W);
    press(K_W);
    n_checks++; if (vals0[5:3] !== 3'd3 || chg0 !== 2'b00) begin n_fail++; $display("FAIL sat_at_max got=%0d/%b exp=3/00", vals0[5:3], chg0); end
    n_checks++; if (vals1[5:3] !== 3'd1 || chg1 !== 2'b10) begin n_fail++; $display("FAIL wrap_max_to_min got=%0d/%b exp=1/10", vals1[5:3], chg1); end
    release_key(K_W);
    press(K_S);
    n_checks++; if (vals0[5:3] !== 3'd2) begin n_fail++; $display("FAIL dn_sat_dut got=%0d exp=2", vals0[5:3]); end
    n_checks++; if (vals1[5:3] !== 3'd3 || chg1 !== 2'b10) begin n_fail++; $display("FAIL wrap_min_to_max got=%0d/%b exp=3/10", vals1[5:3], chg1); end
    release_key(K_S);
  endtask

  task automatic test_release_unmapped();
    do_reset();
    release_key(K_D);
    n_checks++; if (vals0 !== 6'b010_011 || chg0 !== 2'b00) begin n_fail++; $display("FAIL release_no_step got=%h/%b exp=13/00", vals0, chg0); end
    press(K_X);
    n_checks++; if (vals0 !== 6'b010_011 || chg0 !== 2'b00) begin n_fail++; $display("FAIL unmapped_no_step got=%h/%b exp=13/00", vals0, chg0); end
    release_key(K_X);
  endtask

  task automatic test_priority();
    do_reset();
    press(9'h0AA);
    n_checks++; if (vals2 !== {3'd2, 3'd4} || chg2 !== 2'b01) begin n_fail++; $display("FAIL dup_code_priority got=%h/%b exp=14/01", vals2, chg2); end
    release_key(9'h0AA);
  endtask

  task automatic test_repeat_hold();
    int pulses;
    do_reset();
    press(K_W); release_key(K_W);
    press(K_S);
    n_checks++; if (vals0[5:3] !== 3'd2 || chg0 !== 2'b10) begin n_fail++; $display("FAIL hold_first_step got=%0d/%b exp=2/10", vals0[5:3], chg0); end
    pulses = chg0[1];
    for (int t = 1; t <= 30; t++) begin
      tick();
      pulses += chg0[1];
      n_checks++; if (vals0 !== mv(0) || chg0 !== mc(0)) begin n_fail++; $display("FAIL hold_model[t=%0d] got=%h/%b exp=%h/%b", t, vals0, chg0, mv(0), mc(0)); end
      if (t == RD) begin
        n_checks++; if (vals0[5:3] !== 3'(AUTO ? 1 : 2)) begin n_fail++; $display("FAIL hold_delay_step got=%0d exp=%0d", vals0[5:3], AUTO ? 1 : 2); end
      end
    end
    n_checks++; if (pulses !== (AUTO ? 2 : 1)) begin n_fail++; $display("FAIL hold_pulse_count got=%0d exp=%0d", pulses, AUTO ? 2 : 1); end
    release_key(K_S);
  endtask

  task automatic test_reset_during_hold();
    int pulses = 0;
    do_reset();
    press(K_D);
    for (int t = 1; t <= 40; t++) begin
      rst = (t == 22);
      tick();
      rst = 1'b0;
      if (t > 22) pulses += chg0[0];
      if (t == 22) begin
        n_checks++; if (vals0 !== 6'b010_011 || chg0 !== 2'b00) begin n_fail++; $display("FAIL hold_reset_vals got=%h/%b exp=13/00", vals0, chg0); end
      end
      n_checks++; if (vals0 !== mv(0) || chg0 !== mc(0)) begin n_fail++; $display("FAIL hold_rst_model[t=%0d] got=%h/%b exp=%h/%b", t, vals0, chg0, mv(0), mc(0)); end
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL hold_rst_no_steps got=%0d exp=0", pulses); end
    release_key(K_D);
    press(K_D);
    n_checks++; if (vals0[2:0] !== 3'd4 || chg0 !== 2'b01) begin n_fail++; $display("FAIL repress_after_rst got=%0d/%b exp=4/01", vals0[2:0], chg0); end
    release_key(K_D);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      int p;
      logic [8:0] c;
      r = $urandom_range(0, 99);
      p = $urandom_range(0, 6);
      c = (p < 5) ? pool[p] : 9'($urandom);
      rst = (r < 2);
      key_valid = 1'b0;
      if (r < 30) begin
        key_down[c] = 1'b1; key_valid = 1'b1; last_change = c;
      end else if (r < 55) begin
        key_down[c] = 1'b0; key_valid = 1'b1; last_change = c;
      end else if (r < 58) begin
        key_valid = 1'b1; last_change = c;
      end
      tick();
      n_checks++; if (vals0 !== mv(0)) begin n_fail++; $display("FAIL rand_vals0[%0d] got=%h exp=%h", n, vals0, mv(0)); end
      n_checks++; if (chg0 !== mc(0)) begin n_fail++; $display("FAIL rand_chg0[%0d] got=%b exp=%b", n, chg0, mc(0)); end
      n_checks++; if (vals1 !== mv(1)) begin n_fail++; $display("FAIL rand_vals1[%0d] got=%h exp=%h", n, vals1, mv(1)); end
      n_checks++; if (chg1 !== mc(1)) begin n_fail++; $display("FAIL rand_chg1[%0d] got=%b exp=%b", n, chg1, mc(1)); end
    end
    rst = 1'b0; key_valid = 1'b0; key_down = '0;
  endtask

  initial begin
    test_reset();
    test_single_steps();
    test_wrap();
    test_release_unmapped();
    test_priority();
    test_repeat_hold();
    test_reset_during_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_param_controller.md
KEY_PARAM_CONTROLLER -- requirements
Module: key_param_controller

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- NUM_CH, 2: number of independent parameter channels.
- VAL_W, 3: width of each channel value.
- UP_CODES, {9'h023,9'h01D}: packed 9-bit increment scan codes, channel 0 at LSB.
- DN_CODES, {9'h01C,9'h01B}: packed 9-bit decrement scan codes.
- MIN_VALS, {3'd1,3'd1}: packed per-channel minimum values.
- MAX_VALS, {3'd3,3'd5}: packed per-channel maximum values; ch1=3, ch0=5.
- RST_VALS, {3'd2,3'd3}: packed per-channel reset values; ch1=2, ch0=3.
- WRAP, 0: 0 means saturate at the bounds; 1 means wrap max->min and min->max.
- REPEAT_DELAY, 50_000_000: hold cycles before the first auto-repeat step.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat steps.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- key_valid, in, 1: one-cycle strobe from the keyboard decoder.
- last_change, in, 9: scan code of the latest key event.
- key_down, in, 512: current pressed state of every scan code.
- vals, out, NUM_CH*VAL_W: registered channel values.
- changed, out, NUM_CH: one-cycle pulse when a channel value actually changes.

Function
REQ-003 A press event is key_valid=1 with key_down[last_change]=1; release events and unmapped codes SHALL NOT alter vals.
REQ-004 A press matching UP_CODES[i] SHALL increment channel i; a press matching DN_CODES[i] SHALL decrement it; vals SHALL update on the clk edge after the event cycle (latency 1).
REQ-005 With WRAP=0, a step at the bound SHALL leave the value unchanged and SHALL NOT pulse changed[i]; with WRAP=1, the value SHALL wrap and changed[i] SHALL pulse.
REQ-006 changed[i] SHALL be high for exactly the cycle in which vals[i] holds the new value for the first time.
REQ-007 Values SHALL stay within [MIN_VALS[i], MAX_VALS[i]] at all times; arithmetic SHALL be unsigned VAL_W-bit with no overflow carried out of the channel.
REQ-008 If a code appears in more than one slot, the lowest-index UP slot SHALL win, then the lowest-index DN slot.

Reset
REQ-009 Reset SHALL apply on the first clk edge with rst=1: vals=RST_VALS, changed=0, repeat FSM=IDLE, and both counters cleared.
REQ-010 A reset asserted during a hold or repeat SHALL abort the repeat; the key must be released and pressed again before another step occurs.

Configuration
REQ-011 With macro KEY_PARAM_AUTO_REPEAT_EN defined, an auto-repeat FSM SHALL be compiled in with states IDLE, DELAY and REPEAT:
- IDLE->DELAY on a mapped press, latching held_code and its channel and direction; the initial step still occurs per REQ-004.
- DELAY->REPEAT after REPEAT_DELAY cycles, issuing one step.
- In REPEAT, one step SHALL be issued every REPEAT_PERIOD cycles.
- DELAY or REPEAT->IDLE in the cycle key_down[held_code] reads 0.
- A new mapped press while in DELAY or REPEAT SHALL step its own channel, retarget held_code and restart DELAY.
- A repeat step and a press step SHALL never both occur in the same cycle; the press takes priority and the counter restarts.
REQ-012 Without the macro, only single press steps SHALL occur, and the FSM and counters SHALL be absent.

Structure
REQ-013 Package key_param_pkg SHALL hold KEY_CODE_W=9, the repeat-state enum, and the default scan-code constants (A/D/W/S).
REQ-014 Per-channel bounded up/down/wrap arithmetic and the changed pulse SHALL live in sub-module key_param_channel, instantiated NUM_CH times.

Verification
REQ-015 The bench SHALL cover these scenarios (defaults, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- After reset: vals ch0=3, ch1=2; changed=0.
- Press D three times (each with a release): ch0 goes 4,5,5; changed[0] pulses twice only.
- WRAP=1, ch1=3, press W: ch1=1 and changed[1] pulses.
- With the macro, hold S from ch1=3 for 30 cycles: step at press (2), step at cycle 20 (1), then saturated at 1 with no further changed pulses.
- Release event for D, then unmapped code 9'h029 pressed: vals unchanged.
- Hold D with the macro and assert rst at cycle 22 while still holding: vals=RST_VALS and no further steps until D is released and pressed again.
